// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if: sample-in / result-out bundle for mux_tree_pipe.
// master drives samples and observes results; slave is the mux.
interface mux_tree_pipe_if #(
  parameter int W = 8,
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_ch;
  logic           out_err;

  modport master (
    output in_data,
    output in_valid,
    output sel,
    output mode,
    input  out_data,
    input  out_valid,
    input  out_ch,
    input  out_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  sel,
    input  mode,
    output out_data,
    output out_valid,
    output out_ch,
    output out_err
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N:1 W-bit mux as a binary tree of 2:1 levels,
// optionally registered per level, with scan sequencing and range check.
module mux_tree_pipe #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int PIPE = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_tree_pipe_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int L  = SW;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  function automatic int lvl_cnt(input int k);
    int c;
    c = N;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic [SW-1:0] r_scnt;
  logic          r_pmode;
  logic          w_entry;
  logic [SW-1:0] w_ch;
  logic          w_err;

  logic [W-1:0]  w_nd   [L+1][N];
  logic [W-1:0]  r_dat  [L][N];
  logic [SW-1:0] r_mch  [L];
  logic          r_mvld [L];
  logic          r_merr [L];
  logic [SW-1:0] w_kch  [L];
  logic          w_kvld [L];
  logic          w_kerr [L];

  logic [W-1:0]  r_odat;
  logic [SW-1:0] r_och;
  logic          r_ovld;
  logic          r_oerr;

  // entering scan forces channel 0 for that sample
  assign w_entry = bus.mode & ~r_pmode;
  assign w_ch    = bus.mode ? (w_entry ? '0 : r_scnt)
                            : bus.sel;
  assign w_err   = int'(w_ch) >= N;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt  <= '0;
      r_pmode <= 1'b0;
    end else begin
      r_pmode <= bus.mode;
      if (bus.mode) begin
        if (bus.in_valid)
          r_scnt <= (w_ch == LAST) ? '0 : w_ch + 1'b1;
        else if (w_entry)
          r_scnt <= '0;
      end
    end
  end

  // per-level view of the transaction that level is steering
  always_comb begin
    for (int k = 0; k < L; k++) begin
      w_kch[k]  = (PIPE != 0 && k > 0) ? r_mch[k]
                                       : w_ch;
      w_kvld[k] = (PIPE != 0 && k > 0) ? r_mvld[k]
                                       : bus.in_valid;
      w_kerr[k] = (PIPE != 0 && k > 0) ? r_merr[k]
                                       : w_err;
    end
  end

  always_comb begin : tree
    int lo;
    int hi;
    logic [W-1:0] a;
    logic [W-1:0] b;
    lo = 0;
    hi = 0;
    a  = '0;
    b  = '0;
    for (int k = 0; k <= L; k++)
      for (int j = 0; j < N; j++)
        w_nd[k][j] = '0;
    for (int j = 0; j < N; j++)
      w_nd[0][j] = bus.in_data[j*W +: W];
    for (int k = 0; k < L; k++) begin
      for (int j = 0; j < N; j++) begin
        lo = (2 * j < N) ? 2 * j : 0;
        hi = (2 * j + 1 < N) ? 2 * j + 1 : lo;
        a  = (PIPE != 0 && k > 0) ? r_dat[k][lo]
                                  : w_nd[k][lo];
        b  = (PIPE != 0 && k > 0) ? r_dat[k][hi]
                                  : w_nd[k][hi];
        if (j < lvl_cnt(k + 1))
          w_nd[k+1][j] =
            (2 * j + 1 < lvl_cnt(k) && w_kch[k][k])
              ? b : a;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        r_mch[k]  <= '0;
        r_mvld[k] <= 1'b0;
        r_merr[k] <= 1'b0;
        for (int j = 0; j < N; j++)
          r_dat[k][j] <= '0;
      end
    end else begin
      for (int k = 1; k < L; k++) begin
        r_mch[k]  <= w_kch[k-1];
        r_mvld[k] <= w_kvld[k-1];
        r_merr[k] <= w_kerr[k-1];
        for (int j = 0; j < N; j++)
          r_dat[k][j] <= w_nd[k][j];
      end
    end
  end

  // data and channel hold across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_odat <= '0;
      r_och  <= '0;
      r_ovld <= 1'b0;
      r_oerr <= 1'b0;
    end else begin
      r_ovld <= w_kvld[L-1];
      r_oerr <= w_kvld[L-1] & w_kerr[L-1];
      if (w_kvld[L-1]) begin
        r_odat <= w_kerr[L-1] ? '0 : w_nd[L][0];
        r_och  <= w_kch[L-1];
      end
    end
  end

  assign bus.out_data  = r_odat;
  assign bus.out_valid = r_ovld;
  assign bus.out_ch    = r_och;
  assign bus.out_err   = r_oerr;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: five mux configurations driven in lockstep
// and compared every cycle against a queue-based reference model.
module tb_mux_tree_pipe;
  localparam int ND = 5;
  localparam int NN  [ND] = '{8, 5, 8, 2, 3};
  localparam int LAT [ND] = '{3, 3, 1, 1, 1};
  localparam int SWS [ND] = '{3, 3, 3, 1, 2};

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [2:0] c;
    logic       e;
  } rec_t;

  logic        clk;
  logic        rst;
  logic [63:0] din [ND];
  logic        vin [ND];
  logic [2:0]  sin [ND];
  logic        mn  [ND];
  logic [7:0]  od  [ND];
  logic        ov  [ND];
  logic [2:0]  och [ND];
  logic        oe  [ND];

  rec_t       expq [ND][$];
  int         scnt [ND];
  logic       pm   [ND];
  logic [7:0] hd   [ND];
  logic [2:0] hc   [ND];
  int checks = 0;
  int errors = 0;

  mux_tree_pipe_if #(.W(8), .N(8)) if0 ();
  mux_tree_pipe_if #(.W(8), .N(5)) if1 ();
  mux_tree_pipe_if #(.W(8), .N(8)) if2 ();
  mux_tree_pipe_if #(.W(8), .N(2)) if3 ();
  mux_tree_pipe_if #(.W(8), .N(3)) if4 ();

  mux_tree_pipe #(.W(8), .N(8), .PIPE(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  mux_tree_pipe #(.W(8), .N(5), .PIPE(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  mux_tree_pipe #(.W(8), .N(8), .PIPE(0)) u2 (
    .clk(clk), .rst(rst), .bus(if2));
  mux_tree_pipe #(.W(8), .N(2), .PIPE(0)) u3 (
    .clk(clk), .rst(rst), .bus(if3));
  mux_tree_pipe #(.W(8), .N(3), .PIPE(0)) u4 (
    .clk(clk), .rst(rst), .bus(if4));

  assign if0.in_data = din[0];
  assign if1.in_data = din[1][39:0];
  assign if2.in_data = din[2];
  assign if3.in_data = din[3][15:0];
  assign if4.in_data = din[4][23:0];
  assign if0.in_valid = vin[0];
  assign if1.in_valid = vin[1];
  assign if2.in_valid = vin[2];
  assign if3.in_valid = vin[3];
  assign if4.in_valid = vin[4];
  assign if0.sel = sin[0];
  assign if1.sel = sin[1];
  assign if2.sel = sin[2];
  assign if3.sel = sin[3][0];
  assign if4.sel = sin[4][1:0];
  assign if0.mode = mn[0];
  assign if1.mode = mn[1];
  assign if2.mode = mn[2];
  assign if3.mode = mn[3];
  assign if4.mode = mn[4];

  assign od[0] = if0.out_data;
  assign od[1] = if1.out_data;
  assign od[2] = if2.out_data;
  assign od[3] = if3.out_data;
  assign od[4] = if4.out_data;
  assign ov[0] = if0.out_valid;
  assign ov[1] = if1.out_valid;
  assign ov[2] = if2.out_valid;
  assign ov[3] = if3.out_valid;
  assign ov[4] = if4.out_valid;
  assign och[0] = if0.out_ch;
  assign och[1] = if1.out_ch;
  assign och[2] = if2.out_ch;
  assign och[3] = {2'b00, if3.out_ch};
  assign och[4] = {1'b0, if4.out_ch};
  assign oe[0] = if0.out_err;
  assign oe[1] = if1.out_err;
  assign oe[2] = if2.out_err;
  assign oe[3] = if3.out_err;
  assign oe[4] = if4.out_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d got %h exp %h",
             tag, i, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < ND; i++) begin
      chk({tag, "_data"}, i, od[i], 8'h00);
      chk({tag, "_valid"}, i, 8'(ov[i]), 8'h00);
      chk({tag, "_ch"}, i, 8'(och[i]), 8'h00);
      chk({tag, "_err"}, i, 8'(oe[i]), 8'h00);
    end
  endtask

  // reference: output = word[ch] if ch < N, else 0 with err
  task automatic model_step(input int i);
    rec_t r;
    int   ch;
    ch  = mn[i] ? (pm[i] ? scnt[i] : 0) : int'(sin[i]);
    r.v = vin[i];
    r.e = vin[i] && (ch >= NN[i]);
    r.c = 3'(ch);
    r.d = (ch < NN[i]) ? din[i][ch*8 +: 8] : 8'h00;
    if (mn[i]) begin
      if (vin[i]) scnt[i] = (ch + 1) % NN[i];
      else if (!pm[i]) scnt[i] = 0;
    end
    pm[i] = mn[i];
    expq[i].push_back(r);
  endtask

  task automatic check_all();
    rec_t r;
    for (int i = 0; i < ND; i++) begin
      r = '0;
      if (expq[i].size() == LAT[i])
        r = expq[i].pop_front();
      if (r.v) begin
        hd[i] = r.d;
        hc[i] = r.c;
      end
      chk("valid", i, 8'(ov[i]), 8'(r.v));
      chk("err", i, 8'(oe[i]), 8'(r.e));
      chk("data", i, od[i], hd[i]);
      chk("ch", i, 8'(och[i]), 8'(hc[i]));
    end
  endtask

  task automatic cyc();
    for (int i = 0; i < ND; i++) model_step(i);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_clear();
    for (int i = 0; i < ND; i++) begin
      expq[i].delete();
      scnt[i] = 0;
      pm[i]   = 1'b0;
      hd[i]   = 8'h00;
      hc[i]   = 3'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < ND; i++) vin[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      din[i] = '0;
      vin[i] = 1'b0;
      sin[i] = 3'd0;
      mn[i]  = 1'b0;
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    rst = 1'b0;

    // fixed mode sweep, N=8 pipelined and combinational
    din[0] = 64'h1716_1514_1312_1110;
    din[2] = din[0];
    for (int s = 0; s < 8; s++) begin
      sin[0] = 3'(s);
      sin[2] = 3'(7 - s);
      vin[0] = 1'b1;
      vin[2] = 1'b1;
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    // reset with samples in flight
    for (int s = 0; s < 3; s++) begin
      sin[0] = 3'(s + 4);
      vin[0] = 1'b1;
      vin[1] = 1'b1;
      cyc();
    end
    do_reset();
    idle_all();
    repeat (4) cyc();

    // scan mode N=5 with a bubble
    mn[1] = 1'b1;
    for (int s = 0; s < 16; s++) begin
      din[1] = {$urandom, $urandom};
      vin[1] = (s != 12);
      cyc();
    end
    idle_all();
    mn[1] = 1'b0;
    repeat (4) cyc();

    // out-of-range selects beside in-range ones
    din[1] = 64'h0000_00A4_A3A2_A1A0;
    din[4] = 64'h0000_0000_00C2_C1C0;
    for (int s = 0; s < 3; s++) begin
      sin[1] = (s == 1) ? 3'd6 : 3'(s + 3);
      sin[4] = (s == 1) ? 3'd3 : 3'(s);
      vin[1] = 1'b1;
      vin[4] = 1'b1;
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    // scan re-entry restarts at channel 0
    for (int s = 0; s < 8; s++) begin
      mn[1]  = (s < 4 || s >= 6);
      sin[1] = 3'(s - 3);
      din[1] = {$urandom, $urandom};
      vin[1] = 1'b1;
      cyc();
    end
    idle_all();
    mn[1] = 1'b0;
    repeat (4) cyc();

    // single select, combinational tree
    din[2] = 64'h8877_6655_4433_2211;
    sin[2] = 3'd5;
    vin[2] = 1'b1;
    cyc();
    idle_all();
    repeat (2) cyc();

    // random traffic on every configuration
    for (int t = 0; t < 1000; t++) begin
      if (t == 600) do_reset();
      for (int i = 0; i < ND; i++) begin
        din[i] = {$urandom, $urandom};
        vin[i] = ($urandom_range(0, 3) != 0);
        sin[i] = 3'($urandom_range(0, (1 << SWS[i]) - 1));
        if ($urandom_range(0, 9) == 0) mn[i] = ~mn[i];
      end
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
